vend_change_payout: RTL and testbench

//  Change-payout controller at the coin-return end of the vending machine.

---
 rtl/vend_pkg.sv | 34 +++
 rtl/vend_inv_counter.sv | 50 +++++
 rtl/vend_change_payout.sv | 163 ++++++++++++++++
 tb/tb_vend_change_payout.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending-machine change-payout slice.
//   - coin codes driven by the payout FSM
//   - payout FSM state encodings
//   - UNIT_RS: rupee value of one request unit
//   - coin_units(): request units credited when a coin is acknowledged
package vend_pkg;

  localparam int UNIT_RS = 5;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10
  } coin_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_EJECT    = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_DONE     = 3'd4,
    ST_FAULT    = 3'd5
  } payout_state_e;

  // Units of UNIT_RS removed from the remainder when a coin is acknowledged.
  function automatic logic [1:0] coin_units(input coin_e coin);
    case (coin)
      COIN_10: coin_units = 2'd2;
      COIN_5:  coin_units = 2'd1;
      default: coin_units = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_inv_counter.sv
// Saturating up/down hopper inventory counter.
// Ports:
//   clk, rst  clock / async active-high reset (loads INIT)
//   inc       +1 coin (refill); saturates at all-ones
//   dec       -1 coin (ejected); holds at zero
//   count     current registered count
// inc and dec together leave the count unchanged.
module vend_inv_counter #(
  parameter int W    = 8,
  parameter int INIT = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);

  logic [W-1:0] count_next;

  // Next-count selection with saturation at both ends.
  always_comb begin
    count_next = count;
    if (inc && !dec) begin
      if (count != {W{1'b1}}) begin
        count_next = count + W'(1);
      end else begin
        count_next = count;
      end
    end else if (dec && !inc) begin
      if (count != {W{1'b0}}) begin
        count_next = count - W'(1);
      end else begin
        count_next = count;
      end
    end else begin
      count_next = count;
    end
  end

  // Count register, reloaded with INIT on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= W'(INIT);
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/vend_change_payout.sv
// Change-payout controller: accepts a change request (in Rs5 units) over a
// valid/ready handshake and pays it greedily, Rs10 coins first and then Rs5,
// pulsing one hopper at a time and waiting for its ack before the next coin.
// Any amount that cannot be paid from stock is reported as payout_short.
// Ports:
//   clk, rst                 clock / async active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_amt                  change owed in Rs5 units
//   eject_5/eject_10         one-cycle coin drop pulses
//   hopper_ack               hopper confirms the coin dropped
//   refill_5/refill_10       +1 coin into the respective hopper
//   busy                     high in every state except IDLE
//   payout_done/payout_short completion pulse and unpaid remainder
//   inv_5/inv_10             hopper inventory counts
//   fault                    sticky ack-timeout flag
// Build option PAYOUT_TIMEOUT_EN: adds an ack watchdog of TIMEOUT_CYC cycles
// that parks the FSM in FAULT until reset. Without it fault is tied low.
module vend_change_payout
  import vend_pkg::*;
#(
  parameter int AMT_W       = 4,
  parameter int INV_W       = 8,
  parameter int INV5_INIT   = 20,
  parameter int INV10_INIT  = 20,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AMT_W-1:0] req_amt,
  output logic             eject_5,
  output logic             eject_10,
  input  logic             hopper_ack,
  input  logic             refill_5,
  input  logic             refill_10,
  output logic             busy,
  output logic             payout_done,
  output logic [AMT_W-1:0] payout_short,
  output logic [INV_W-1:0] inv_5,
  output logic [INV_W-1:0] inv_10,
  output logic             fault
);

  payout_state_e    state;
  logic [AMT_W-1:0] rem;
  coin_e            coin;

`ifdef PAYOUT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  assign fault = 1'b0;
`endif

  // The eject pulses are high exactly in the EJECT cycle, so they double as
  // the inventory decrement strobes.
  vend_inv_counter #(.W(INV_W), .INIT(INV5_INIT)) u_inv_5 (
    .clk   (clk),
    .rst   (rst),
    .inc   (refill_5),
    .dec   (eject_5),
    .count (inv_5)
  );

  vend_inv_counter #(.W(INV_W), .INIT(INV10_INIT)) u_inv_10 (
    .clk   (clk),
    .rst   (rst),
    .inc   (refill_10),
    .dec   (eject_10),
    .count (inv_10)
  );

  // Payout FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      rem          <= '0;
      coin         <= COIN_NONE;
      req_ready    <= 1'b1;
      busy         <= 1'b0;
      eject_5      <= 1'b0;
      eject_10     <= 1'b0;
      payout_done  <= 1'b0;
      payout_short <= '0;
`ifdef PAYOUT_TIMEOUT_EN
      fault        <= 1'b0;
      wait_cnt     <= '0;
`endif
    end else begin
      eject_5      <= 1'b0;
      eject_10     <= 1'b0;
      payout_done  <= 1'b0;
      payout_short <= '0;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            rem       <= req_amt;
            state     <= ST_SELECT;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_SELECT: begin
          // Rs10 only when at least two units remain, so it never overpays.
          if (rem == '0) begin
            state <= ST_DONE;
          end else if ((rem >= AMT_W'(2)) && (inv_10 != '0)) begin
            coin     <= COIN_10;
            eject_10 <= 1'b1;
            state    <= ST_EJECT;
          end else if (inv_5 != '0) begin
            coin    <= COIN_5;
            eject_5 <= 1'b1;
            state   <= ST_EJECT;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_EJECT: begin
          state <= ST_WAIT_ACK;
`ifdef PAYOUT_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ST_WAIT_ACK: begin
          if (hopper_ack) begin
            rem   <= rem - AMT_W'(coin_units(coin));
            state <= ST_SELECT;
          end
`ifdef PAYOUT_TIMEOUT_EN
          // The unacked coin is not credited: rem still includes it.
          else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            state        <= ST_FAULT;
            fault        <= 1'b1;
            payout_done  <= 1'b1;
            payout_short <= rem;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        ST_DONE: begin
          payout_done  <= 1'b1;
          payout_short <= rem;
          state        <= ST_IDLE;
          req_ready    <= 1'b1;
          busy         <= 1'b0;
        end
        ST_FAULT: begin
          // Parked until reset; ready stays low and busy stays high.
          state <= ST_FAULT;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_change_payout.sv
// Directed self-checking bench for vend_change_payout.
module tb_vend_change_payout;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_amt;
  logic       eject_5;
  logic       eject_10;
  logic       hopper_ack;
  logic       refill_5;
  logic       refill_10;
  logic       busy;
  logic       payout_done;
  logic [3:0] payout_short;
  logic [7:0] inv_5;
  logic [7:0] inv_10;
  logic       fault;

  int n_tests = 0;
  int n_fail  = 0;

  // hopper model / monitor state
  bit ack_en          = 1'b1;
  bit ack_pend        = 1'b0;
  bit refill_on_eject = 1'b0;
  int n5 = 0;
  int n10 = 0;
  int done_cnt = 0;
  int first_coin = 0;

  vend_change_payout dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_amt      (req_amt),
    .eject_5      (eject_5),
    .eject_10     (eject_10),
    .hopper_ack   (hopper_ack),
    .refill_5     (refill_5),
    .refill_10    (refill_10),
    .busy         (busy),
    .payout_done  (payout_done),
    .payout_short (payout_short),
    .inv_5        (inv_5),
    .inv_10       (inv_10),
    .fault        (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Hopper model: ack one cycle after each eject; also counts pulses.
  initial begin
    hopper_ack = 1'b0;
    forever begin
      @(negedge clk);
      hopper_ack = ack_pend;
      ack_pend   = ack_en && (eject_5 || eject_10);
      if (eject_5) begin
        n5++;
        if (first_coin == 0) first_coin = 5;
      end
      if (eject_10) begin
        n10++;
        if (first_coin == 0) first_coin = 10;
      end
      if (payout_done) done_cnt++;
      if (refill_on_eject) refill_10 = eject_10;
    end
  end

  task automatic clear_counts();
    n5 = 0;
    n10 = 0;
    first_coin = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one request and wait (bounded) for payout_done.
  // lat = number of negedges after the drive negedge at which done was seen.
  task automatic run_request(input int amt, output int lat, output int shrt);
    @(negedge clk);
    req_valid = 1'b1;
    req_amt   = 4'(amt);
    lat  = -1;
    shrt = -1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i == 1) req_valid = 1'b0;
      if (payout_done) begin
        lat  = i;
        shrt = int'(payout_short);
        break;
      end
    end
    if (lat < 0) check("done_timeout", 0, 1);
  endtask

  initial begin
    int lat;
    int shrt;
    int dc;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_amt   = 4'd0;
    refill_5  = 1'b0;
    refill_10 = 1'b0;
    do_reset();

    // reset state
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", payout_done, 0);
    check("rst_short", payout_short, 0);
    check("rst_inv5", inv_5, 20);
    check("rst_inv10", inv_10, 20);
    check("rst_fault", fault, 0);

    // 1: amt=3, full stock -> Rs10 then Rs5
    clear_counts();
    run_request(3, lat, shrt);
    check("t1_short", shrt, 0);
    check("t1_n10", n10, 1);
    check("t1_n5", n5, 1);
    check("t1_first", first_coin, 10);
    check("t1_inv10", inv_10, 19);
    check("t1_inv5", inv_5, 19);

    // 4: amt=0 -> done 2 edges after accept (3rd negedge after drive)
    clear_counts();
    run_request(0, lat, shrt);
    check("t4_lat", lat, 3);
    check("t4_short", shrt, 0);
    check("t4_noeject", n5 + n10, 0);

    // 2: drain Rs10 from a fresh reset, then amt=4 -> four Rs5
    do_reset();
    for (int k = 0; k < 20; k++) run_request(2, lat, shrt);
    check("t2_drain_inv10", inv_10, 0);
    check("t2_drain_inv5", inv_5, 20);
    clear_counts();
    run_request(4, lat, shrt);
    check("t2_short", shrt, 0);
    check("t2_n5", n5, 4);
    check("t2_n10", n10, 0);
    check("t2_inv5", inv_5, 16);

    // 3: inv_10=5, inv_5=0, amt=3 -> one Rs10, short=1
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      refill_10 = 1'b1;
    end
    @(negedge clk);
    refill_10 = 1'b0;
    check("t3_refill_inv10", inv_10, 5);
    for (int k = 0; k < 16; k++) run_request(1, lat, shrt);
    check("t3_drain_inv5", inv_5, 0);
    clear_counts();
    run_request(3, lat, shrt);
    check("t3_short", shrt, 1);
    check("t3_n10", n10, 1);
    check("t3_n5", n5, 0);
    check("t3_inv10", inv_10, 4);

    // 5: refill_10 coincident with eject_10 -> unchanged; refill saturates
    clear_counts();
    refill_on_eject = 1'b1;
    run_request(2, lat, shrt);
    refill_on_eject = 1'b0;
    refill_10 = 1'b0;
    check("t5_n10", n10, 1);
    check("t5_inv10", inv_10, 4);
    refill_5 = 1'b1;
    for (int k = 0; k < 270; k++) @(negedge clk);
    refill_5 = 1'b0;
    @(negedge clk);
    check("t5_sat_inv5", inv_5, 255);

    // 6: reset during WAIT_ACK
    ack_en = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_amt   = 4'd2;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge clk);
    check("t6_busy_mid", busy, 1);
    check("t6_inv10_mid", inv_10, 3);
    dc  = done_cnt;
    rst = 1'b1;
    #1;
    check("t6_rst_ready", req_ready, 1);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_inv10", inv_10, 20);
    check("t6_rst_inv5", inv_5, 20);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ack_en = 1'b1;
    for (int k = 0; k < 6; k++) @(negedge clk);
    check("t6_no_done", done_cnt, dc);
    check("t6_ready_after", req_ready, 1);

    // max request, full stock: 7 x Rs10 + 1 x Rs5
    clear_counts();
    run_request(15, lat, shrt);
    check("t7_short", shrt, 0);
    check("t7_n10", n10, 7);
    check("t7_n5", n5, 1);
    check("t7_inv10", inv_10, 13);
    check("t7_inv5", inv_5, 19);

`ifdef PAYOUT_TIMEOUT_EN
    // watchdog: no ack -> FAULT, short is the full uncredited remainder
    do_reset();
    ack_en = 1'b0;
    run_request(3, lat, shrt);
    check("to_short", shrt, 3);
    @(negedge clk);
    check("to_fault", fault, 1);
    check("to_ready", req_ready, 0);
    check("to_busy", busy, 1);
    ack_en = 1'b1;
    do_reset();
    check("to_fault_cleared", fault, 0);
`else
    check("fault_tied_low", fault, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
